// File: rtl/control_sequencer.sv
// Hardwired control sequencer for a simple register-to-register datapath:
// fetches through T0..T2, decodes in T3 and executes the ALU op in T4..T5.
//
// state | meaning
// IDLE  | waiting for Run, all strobes low
// T0    | PC to MAR, start PC increment
// T1    | memory read, waits for MemReady (PC update in first cycle only)
// T2    | MDR to IR
// T3    | decode; drive Rb to Y
// T4    | drive Rc, ALU op into Z
// T5    | Z to Ra; continue with T0 if Run
// HALT  | absorbing until Clear
module control_sequencer (
    input  logic        clk,
    input  logic        Clear,
    input  logic        Run,
    input  logic        MemReady,
    input  logic [31:0] IR,
    output logic        PCout,
    output logic        IncPC,
    output logic        MARin,
    output logic        Zin,
    output logic        Read,
    output logic        MDRin,
    output logic        MDRout,
    output logic        Zlowout,
    output logic        PCin,
    output logic        IRin,
    output logic        Yin,
    output logic [7:0]  Rin,
    output logic [15:0] Rout,
    output logic [4:0]  ALUop,
    output logic        Busy,
    output logic        Halted,
    output logic        Illegal
);

    typedef enum logic [2:0] {
        S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_HALT
    } state_t;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_HALT = 5'b11011;

    state_t     state;
    logic [4:0] op_q;
    logic [3:0] ra_q;
    logic [3:0] rc_q;
    logic       unused_ir;

    assign unused_ir = ^IR[14:0];

    function automatic logic alu_op_ok(input logic [4:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
    endfunction

    // Outputs are registered for the state being entered, so each branch
    // sets the strobes of its destination state.
    always_ff @(posedge clk or negedge Clear) begin
        if (!Clear) begin
            state   <= S_IDLE;
            op_q    <= '0;
            ra_q    <= '0;
            rc_q    <= '0;
            PCout   <= 1'b0;
            IncPC   <= 1'b0;
            MARin   <= 1'b0;
            Zin     <= 1'b0;
            Read    <= 1'b0;
            MDRin   <= 1'b0;
            MDRout  <= 1'b0;
            Zlowout <= 1'b0;
            PCin    <= 1'b0;
            IRin    <= 1'b0;
            Yin     <= 1'b0;
            Rin     <= '0;
            Rout    <= '0;
            ALUop   <= '0;
            Busy    <= 1'b0;
            Halted  <= 1'b0;
            Illegal <= 1'b0;
        end else begin
            PCout   <= 1'b0;
            IncPC   <= 1'b0;
            MARin   <= 1'b0;
            Zin     <= 1'b0;
            Read    <= 1'b0;
            MDRin   <= 1'b0;
            MDRout  <= 1'b0;
            Zlowout <= 1'b0;
            PCin    <= 1'b0;
            IRin    <= 1'b0;
            Yin     <= 1'b0;
            Rin     <= '0;
            Rout    <= '0;
            ALUop   <= '0;
            Busy    <= 1'b0;
            Halted  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (Run) begin
                        state <= S_T0;
                        Busy  <= 1'b1;
                        PCout <= 1'b1;
                        MARin <= 1'b1;
                        IncPC <= 1'b1;
                        Zin   <= 1'b1;
                    end
                end
                S_T0: begin
                    state   <= S_T1;
                    Busy    <= 1'b1;
                    Zlowout <= 1'b1;
                    PCin    <= 1'b1;
                    Read    <= 1'b1;
                    MDRin   <= 1'b1;
                end
                S_T1: begin
                    Busy <= 1'b1;
                    if (MemReady) begin
                        state  <= S_T2;
                        MDRout <= 1'b1;
                        IRin   <= 1'b1;
                    end else begin
                        Read  <= 1'b1;
                        MDRin <= 1'b1;
                    end
                end
                S_T2: begin
                    state <= S_T3;
                    Busy  <= 1'b1;
                    op_q  <= IR[31:27];
                    ra_q  <= IR[26:23];
                    rc_q  <= IR[18:15];
                    // Rout here carries the latched Rb for the T3 cycle.
                    if (alu_op_ok(IR[31:27]) && !IR[26]) begin
                        Rout <= 16'd1 << IR[22:19];
                        Yin  <= 1'b1;
                    end
                end
                S_T3: begin
                    if (op_q == OP_HALT) begin
                        state  <= S_HALT;
                        Halted <= 1'b1;
                    end else if (!alu_op_ok(op_q) || ra_q[3]) begin
                        state   <= S_IDLE;
                        Illegal <= 1'b1;
                    end else begin
                        state <= S_T4;
                        Busy  <= 1'b1;
                        Rout  <= 16'd1 << rc_q;
                        ALUop <= op_q;
                        Zin   <= 1'b1;
                    end
                end
                S_T4: begin
                    state   <= S_T5;
                    Busy    <= 1'b1;
                    Zlowout <= 1'b1;
                    Rin     <= 8'd1 << ra_q[2:0];
                end
                S_T5: begin
                    if (Run) begin
                        state <= S_T0;
                        Busy  <= 1'b1;
                        PCout <= 1'b1;
                        MARin <= 1'b1;
                        IncPC <= 1'b1;
                        Zin   <= 1'b1;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_HALT: begin
                    Halted <= 1'b1;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 The module SHALL have these ports, clock and reset first:
- clk  in  1  system clock; all state changes on its rising edge
- Clear  in  1  reset, asynchronous and active-low; Clear=0 forces reset state immediately
- Run  in  1  start/continue request, sampled in IDLE and T5
- MemReady  in  1  memory read-complete handshake from the memory stage
- IR  in  32  instruction register contents from the datapath
- PCout, IncPC, MARin, Zin, Read, MDRin, MDRout, Zlowout, PCin, IRin, Yin  out  1 each  datapath control strobes
- Rin  out  8  one-hot write enables for R0..R7
- Rout  out  16  one-hot bus-drive enables for R0..R15
- ALUop  out  5  ALU operation select to the datapath
- Busy  out  1  high in every state except IDLE and HALT
- Halted  out  1  high in HALT
- Illegal  out  1  sticky illegal-instruction flag

Function
REQ-002 Field decode SHALL be opcode=IR[31:27], Ra=IR[26:23], Rb=IR[22:19], Rc=IR[18:15].
REQ-003 Supported opcodes SHALL be ADD=00011, SUB=00100, AND=00101, OR=00110, HALT=11011; ALUop SHALL equal opcode during T4 and 00000 in every other state.
REQ-004 States SHALL be IDLE, T0, T1, T2, T3, T4, T5, HALT; all outputs are Moore (decoded from state, latched IR fields).
REQ-005 IDLE: all strobes 0; go to T0 when Run=1, otherwise stay.
REQ-006 T0: PCout=1, MARin=1, IncPC=1, Zin=1; next state T1.
REQ-007 T1: Zlowout=1, PCin=1 in the first T1 cycle only; Read=1 and MDRin=1 in every T1 cycle; stay in T1 while MemReady=0, go to T2 on the cycle MemReady=1.
REQ-008 T2: MDRout=1, IRin=1; next state T3.
REQ-009 T3 SHALL decode the opcode. HALT goes to HALT with no strobes. An unsupported opcode or Ra>7 sets Illegal and goes to IDLE with no strobes. Otherwise Rout[Rb]=1 and Yin=1, then go to T4.
REQ-010 T4: Rout[Rc]=1, ALUop=opcode, Zin=1; next state T5.
REQ-011 T5: Zlowout=1, Rin[Ra]=1; next state T0 if Run=1, else IDLE.
REQ-012 Rin and Rout SHALL be one-hot or zero in every cycle. No two bus drivers (PCout, MDRout, Zlowout, any Rout bit) SHALL assert in the same cycle.
REQ-013 Rb=Rc is legal; Rout[Rb] asserts in T3 and Rout[Rc] in T4 independently.
REQ-014 Ra, Rb, Rc and opcode SHALL be latched from IR at the T2-to-T3 edge; IR changes after that edge do not affect T3-T5.
REQ-015 HALT SHALL be absorbing; only Clear leaves it.
REQ-016 A MemReady level outside T1 SHALL be ignored.
REQ-017 Illegal SHALL stay 1 until Clear; it SHALL NOT block later instructions.
REQ-018 The no-wait instruction latency, Run seen in IDLE to Rin strobe, SHALL be 6 cycles (T0..T5); each extra MemReady=0 cycle in T1 adds one cycle.

Reset
REQ-019 Clear=0 SHALL immediately force state IDLE, clear all strobes, Rin=0, Rout=0, ALUop=0, Busy=0, Halted=0, Illegal=0, and clear the latched fields, regardless of the current state.
REQ-020 Deasserting Clear SHALL take effect at the next clk edge; Clear asserted mid-instruction (e.g. in T4) SHALL abort the instruction with no Rin strobe.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- IR=0x21890000 (SUB R3,R1,R2), Run=1, MemReady=1 -> T3 Rout=0x0002, Yin; T4 Rout=0x0004, ALUop=00100, Zin; T5 Rin=0x08, Zlowout.
- Same IR, MemReady low for 3 cycles -> T1 held 4 cycles; PCin pulses once; Read and MDRin high all 4 cycles; Rin=0x08 at cycle 9.
- IR=0xD8000000 (HALT) -> Halted=1, Busy=0 after T3; Run toggling has no effect; Clear=0 -> IDLE.
- Opcode 01111, or ADD with Ra=9 -> Illegal=1, return to IDLE, no Rin; next valid ADD completes with Illegal still 1.
- Clear=0 asynchronously in T4 -> all outputs 0 before the next edge; no Rin; restart from T0 after Clear=1 and Run=1.
- Run held 1 over back-to-back ADD R1,R1,R1 -> T5 goes directly to T0; Rout=0x0002 in both T3 and T4; a one-hot/bus-contention assertion is checked every cycle.
